scan_chain_ctrl: RTL
====================

Name: scan_chain_ctrl

Overview:
- Scan test controller that drives a chain of N scan D flip-flops (ports SE/SI in, Q out) directly upstream of the chain.
- For each test it shifts a pattern in, pulses one capture cycle, shifts the response out, and compares the response against an expected vector.
- It is the pattern source and response sink for the scan flip-flop chain. It produces SE/SI for the chain and consumes the chain's last Q as SO.

Parameters:
- N, 4, scan chain length in flops; legal range 1..255.
- CW, $clog2(N+1), bit-counter width; derived, not overridden.

Ports:
- CLK  input  1  rising-edge clock shared with the scan chain
- R  input  1  reset, asynchronous, active-low
- START  input  1  request a test; sampled only in IDLE
- PATTERN  input  N  stimulus vector; bit 0 shifted first
- EXPECT  input  N  expected response vector
- SO  input  1  scan-out (Q of last chain flop)
- SE  output  1  scan enable to every chain flop
- SI  output  1  scan data into first chain flop
- BUSY  output  1  test in progress
- DONE  output  1  one-cycle completion pulse
- FAIL  output  1  response mismatch, valid from DONE until next accepted START
- CAPTURED  output  N  shifted-out response; bit 0 shifted out first

Behaviour:
- Reset (R=0, async): state=IDLE; SE=0, SI=0, BUSY=0, DONE=0, FAIL=0, CAPTURED=0, counter=0. Reset mid-test aborts immediately; chain contents are don't-care. After R rises, the controller waits for a new START.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN.
- IDLE:
  - On START=1 at an edge, load the pattern shift register from PATTERN, latch EXPECT, clear FAIL and CAPTURED, clear the counter, and go to SHIFT_IN.
  - START=0 keeps the state in IDLE.
- SHIFT_IN:
  - SE=1, SI = pattern_sr[0].
  - Each edge shifts pattern_sr right by 1 and increments the counter.
  - After N edges, go to CAPTURE.
  - Result: the flop j positions from the SO end holds PATTERN[j].
- CAPTURE:
  - Exactly 1 cycle, with SE=0 and SI=0; the chain loads its functional D.
  - Clear the counter and go to SHIFT_OUT.
- SHIFT_OUT:
  - SE=1, SI=0.
  - At each edge, sample SO (pre-edge value) into CAPTURED[counter], then increment the counter.
  - After N edges, go to FIN.
  - Result: CAPTURED[j] is the captured value of the flop j positions from the SO end.
- FIN:
  - 1 cycle with SE=0 and DONE=1.
  - FAIL = (CAPTURED != latched EXPECT), computed from the fully assembled CAPTURED.
  - Go to IDLE.
- Latency: the START edge through the last SHIFT_OUT edge spans 2N+1 edges. DONE is high during cycle 2N+2 after the START edge.
- BUSY=1 in every state except IDLE. Outputs are registered; SI changes only on CLK edges.
- START while BUSY=1 is ignored; no queuing. START held high through FIN restarts on the first IDLE edge.
- PATTERN and EXPECT may change freely after the accepting edge.
- N=1: SHIFT_IN and SHIFT_OUT each last exactly 1 cycle.
- Counter uses CW bits. Terminal count is N-1 on the shifting edge, with no wrap beyond N.
- CAPTURED and FAIL hold their values in IDLE until the next accepted START.

Test Plan:
- N=4, chain D_k=Q_k (hold), PATTERN=4'b1010, EXPECT=4'b1010, START pulse -> SE high 4 cycles, low 1, high 4; SI sequence 0,1,0,1; DONE exactly 10 cycles after START edge; CAPTURED=4'b1010, FAIL=0.
- N=4, chain D_k=~Q_k, PATTERN=4'b1100, EXPECT=4'b0011 -> CAPTURED=4'b0011, FAIL=0. Repeat with EXPECT=4'b1100 -> FAIL=1.
- START re-asserted at cycles 3 and 7 of a running test -> ignored; single DONE pulse; BUSY stays 1 until DONE.
- R driven low mid-SHIFT_OUT (asynchronously, between edges) -> SE, SI, BUSY, DONE, FAIL and CAPTURED go to 0 without waiting for CLK. No DONE follows. A new START after R=1 completes normally in 10 cycles.
- N=1 build, hold chain, PATTERN=1, EXPECT=1 -> SE high/low/high for one cycle each; DONE at cycle 4; CAPTURED=1, FAIL=0.
- Back-to-back: START held high continuously with PATTERNs 4'hF then 4'h0 -> second test starts on the edge after FIN. CAPTURED is 4'hF then 4'h0; FAIL cleared at the second START.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: shifts a pattern into an N-flop scan chain, pulses one
// capture cycle, shifts the response out and compares it against an expected vector.
module scan_chain_ctrl #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         R,
    input  logic         START,
    input  logic [N-1:0] PATTERN,
    input  logic [N-1:0] EXPECT,
    input  logic         SO,
    output logic         SE,
    output logic         SI,
    output logic         BUSY,
    output logic         DONE,
    output logic         FAIL,
    output logic [N-1:0] CAPTURED
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        FIN       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  pattern_q, pattern_d;
    logic [N-1:0]  expect_q, expect_d;
    logic [N-1:0]  captured_q, captured_d;
    logic          fail_q, fail_d;
    logic          se_q, se_d;
    logic          si_q, si_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pattern_d  = pattern_q;
        expect_d   = expect_q;
        captured_d = captured_q;
        fail_d     = fail_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = SHIFT_IN;
                    pattern_d  = PATTERN;
                    expect_d   = EXPECT;
                    fail_d     = 1'b0;
                    captured_d = {N{1'b0}};
                    count_d    = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_IN: begin
                pattern_d = pattern_q >> 1'b1;
                if (count_q == LAST) begin
                    state_d = CAPTURE;
                    count_d = {CW{1'b0}};
                end else begin
                    count_d = count_q + ONE;
                end
            end
            CAPTURE: begin
                count_d = {CW{1'b0}};
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                // SO still shows the pre-edge value of the flop nearest the output.
                for (int i = 0; i < N; i++) begin
                    if (count_q == CW'(i)) begin
                        captured_d[i] = SO;
                    end else begin
                        captured_d[i] = captured_q[i];
                    end
                end
                if (count_q == LAST) begin
                    state_d = FIN;
                    count_d = {CW{1'b0}};
                    fail_d  = (captured_d != expect_q);
                end else begin
                    count_d = count_q + ONE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid right after the edge.
        busy_d = (state_d != IDLE);
        se_d   = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
        si_d   = (state_d == SHIFT_IN) ? pattern_d[0] : 1'b0;
        done_d = (state_d == FIN);
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q    <= IDLE;
            count_q    <= {CW{1'b0}};
            pattern_q  <= {N{1'b0}};
            expect_q   <= {N{1'b0}};
            captured_q <= {N{1'b0}};
            fail_q     <= 1'b0;
            se_q       <= 1'b0;
            si_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pattern_q  <= pattern_d;
            expect_q   <= expect_d;
            captured_q <= captured_d;
            fail_q     <= fail_d;
            se_q       <= se_d;
            si_q       <= si_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SE       = se_q;
    assign SI       = si_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign FAIL     = fail_q;
    assign CAPTURED = captured_q;

endmodule
